// File: rtl/sprite_scanline_engine_if.sv
// Bus bundle between the sprite scanline engine and its surroundings: sprite RAM read port,
// line control, slot descriptors for the tile draw units and the pixel compositor path.
interface sprite_scanline_engine_if #(
    parameter int NUM_SPRITES = 64,
    parameter int SLOTS       = 8,
    parameter int SPRITE_H    = 16,
    parameter int RGB_W       = 12
) ();
    localparam int ADDR_W = $clog2(NUM_SPRITES);
    localparam int ROW_W  = $clog2(SPRITE_H);

    logic                     line_start;
    logic [9:0]               next_line;
    logic [ADDR_W-1:0]        oam_addr;
    logic [31:0]              oam_rdata;
    logic [SLOTS*32-1:0]      slot_desc;
    logic [SLOTS*ROW_W-1:0]   slot_row;
    logic [SLOTS-1:0]         slot_valid;
    logic                     scan_busy;
    logic                     overflow;
    logic                     scan_late;
    logic [SLOTS*RGB_W-1:0]   slot_pix;
    logic [SLOTS-1:0]         slot_opaque;
    logic                     pix_valid;
    logic [RGB_W-1:0]         bg_rgb;
    logic                     bg_opaque;
    logic [RGB_W-1:0]         rgb_out;
    logic                     rgb_valid;

    // Environment side: timing generator, sprite RAM and draw units.
    modport master (
        output line_start, next_line, oam_rdata, slot_pix, slot_opaque,
               pix_valid, bg_rgb, bg_opaque,
        input  oam_addr, slot_desc, slot_row, slot_valid, scan_busy,
               overflow, scan_late, rgb_out, rgb_valid
    );

    // Engine side.
    modport slave (
        input  line_start, next_line, oam_rdata, slot_pix, slot_opaque,
               pix_valid, bg_rgb, bg_opaque,
        output oam_addr, slot_desc, slot_row, slot_valid, scan_busy,
               overflow, scan_late, rgb_out, rgb_valid
    );
endinterface

// File: rtl/sprite_scanline_engine.sv
// Sprite line evaluator: scans sprite RAM into a pending slot bank for the next line, swaps it
// to the active bank on line_start, and composites the per-slot pixels over the background.
module sprite_scanline_engine #(
    parameter int NUM_SPRITES = 64,
    parameter int SLOTS       = 8,
    parameter int SPRITE_H    = 16,
    parameter int RGB_W       = 12
) (
    input  logic                    clk,
    input  logic                    rstn,
    sprite_scanline_engine_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_SPRITES);
    localparam int ROW_W  = $clog2(SPRITE_H);
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int HIT_W  = $clog2(SLOTS + 1);
    localparam int CYC_W  = ADDR_W + 1;

    localparam logic [CYC_W-1:0]      LAST_CYC   = CYC_W'(NUM_SPRITES);
    localparam logic [HIT_W-1:0]      HIT_FULL   = HIT_W'(SLOTS);
    localparam logic signed [10:0]    SPRITE_H_S = 11'(SPRITE_H);
    localparam logic [ROW_W-1:0]      ROW_MAX    = ROW_W'(SPRITE_H - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Lines above the sprite top give a negative distance, so there is no wrap past line 1023.
    function automatic logic signed [10:0] line_dist(input logic [9:0] line, input logic [9:0] y);
        return $signed({1'b0, line}) - $signed({1'b0, y});
    endfunction

    function automatic logic [ROW_W-1:0] sprite_row(input logic signed [10:0] d, input logic vflip);
        logic [ROW_W-1:0] r;
        r = d[ROW_W-1:0];
        return vflip ? ROW_MAX - r : r;
    endfunction

    state_t                       state, state_nxt;
    logic [CYC_W-1:0]             cyc;
    logic [HIT_W-1:0]             hit_cnt, hit_cnt_nxt;
    logic [9:0]                   line_q;

    logic [SLOTS-1:0][31:0]       pend_desc, pend_desc_nxt, act_desc;
    logic [SLOTS-1:0][ROW_W-1:0]  pend_row, pend_row_nxt, act_row;
    logic [SLOTS-1:0]             pend_valid, pend_valid_nxt, act_valid;
    logic                         pend_ovf, pend_ovf_nxt;
    logic                         ovf_q, late_q;

    logic                         chk_vld_p1;
    logic signed [10:0]           dist_p1;
    logic                         hit_p1;
    logic [SLOT_W-1:0]            slot_sel;

    logic [SLOTS-1:0][RGB_W-1:0]  slot_pix_arr;
    logic                         win_found;
    logic [SLOT_W-1:0]            win_sel;
    logic [RGB_W-1:0]             comp_rgb;
    logic [RGB_W-1:0]             rgb_p1;
    logic                         vld_p1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Stage p1: RAM data for the address issued last cycle is checked against the line.
    always_comb begin
        state_nxt      = state;
        hit_cnt_nxt    = hit_cnt;
        pend_desc_nxt  = pend_desc;
        pend_row_nxt   = pend_row;
        pend_valid_nxt = pend_valid;
        pend_ovf_nxt   = pend_ovf;

        chk_vld_p1 = (state == SCAN) && (cyc != '0);
        dist_p1    = line_dist(line_q, bus.oam_rdata[9:0]);
        hit_p1     = chk_vld_p1 && bus.oam_rdata[31] && !dist_p1[10] && (dist_p1 < SPRITE_H_S);
        slot_sel   = hit_cnt[SLOT_W-1:0];

        if (hit_p1) begin
            if (hit_cnt == HIT_FULL) begin
                pend_ovf_nxt = 1'b1;
            end else begin
                pend_desc_nxt[slot_sel]  = bus.oam_rdata;
                pend_row_nxt[slot_sel]   = sprite_row(dist_p1, bus.oam_rdata[30]);
                pend_valid_nxt[slot_sel] = 1'b1;
                hit_cnt_nxt              = hit_cnt + 1'b1;
            end
        end

        if (bus.line_start) begin
            state_nxt = SCAN;
        end else if (state == SCAN) begin
            if ((cyc == LAST_CYC) || (hit_p1 && (hit_cnt == HIT_FULL)))
                state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc        <= '0;
            hit_cnt    <= '0;
            line_q     <= '0;
            pend_desc  <= '0;
            pend_row   <= '0;
            pend_valid <= '0;
            pend_ovf   <= 1'b0;
        end else if (bus.line_start) begin
            cyc        <= '0;
            hit_cnt    <= '0;
            line_q     <= bus.next_line;
            pend_desc  <= '0;
            pend_row   <= '0;
            pend_valid <= '0;
            pend_ovf   <= 1'b0;
        end else if (state == SCAN) begin
            cyc        <= (state_nxt == SCAN) ? cyc + 1'b1 : '0;
            hit_cnt    <= hit_cnt_nxt;
            pend_desc  <= pend_desc_nxt;
            pend_row   <= pend_row_nxt;
            pend_valid <= pend_valid_nxt;
            pend_ovf   <= pend_ovf_nxt;
        end
    end

    // The commit takes the _nxt view so a hit checked on the line_start cycle is not lost.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act_desc  <= '0;
            act_row   <= '0;
            act_valid <= '0;
            ovf_q     <= 1'b0;
            late_q    <= 1'b0;
        end else if (bus.line_start) begin
            act_desc  <= pend_desc_nxt;
            act_row   <= pend_row_nxt;
            act_valid <= pend_valid_nxt;
            ovf_q     <= pend_ovf_nxt;
            late_q    <= (state == SCAN);
        end
    end

    assign slot_pix_arr = bus.slot_pix;

    // Stage p0: priority pick of the lowest opaque active slot, then the behind-bg test.
    always_comb begin
        win_found = 1'b0;
        win_sel   = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!win_found && act_valid[i] && bus.slot_opaque[i]) begin
                win_found = 1'b1;
                win_sel   = SLOT_W'(i);
            end
        end
        comp_rgb = bus.bg_rgb;
        if (win_found && !(act_desc[win_sel][28] && bus.bg_opaque))
            comp_rgb = slot_pix_arr[win_sel];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rgb_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= bus.pix_valid;
            if (bus.pix_valid) rgb_p1 <= comp_rgb;
        end
    end

    assign bus.oam_addr   = cyc[ADDR_W-1:0];
    assign bus.scan_busy  = (state == SCAN);
    assign bus.slot_desc  = act_desc;
    assign bus.slot_row   = act_row;
    assign bus.slot_valid = act_valid;
    assign bus.overflow   = ovf_q;
    assign bus.scan_late  = late_q;
    assign bus.rgb_out    = rgb_p1;
    assign bus.rgb_valid  = vld_p1;
endmodule

// File: tb/tb_sprite_scanline_engine.sv
// Bench for sprite_scanline_engine: directed line/compositor cases plus random sprite tables,
// all compared with a list-walking reference model of the line evaluation and pixel merge.
module tb_sprite_scanline_engine;
    localparam int NUM  = 64;
    localparam int SL   = 8;
    localparam int H    = 16;
    localparam int RW   = 12;
    localparam int ROWW = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    sprite_scanline_engine_if #(.NUM_SPRITES(NUM), .SLOTS(SL), .SPRITE_H(H), .RGB_W(RW)) bus ();

    sprite_scanline_engine #(.NUM_SPRITES(NUM), .SLOTS(SL), .SPRITE_H(H), .RGB_W(RW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [31:0] oam [NUM];
    always @(posedge clk) bus.oam_rdata <= oam[bus.oam_addr];

    int n_checks = 0;
    int n_errors = 0;

    logic [SL*32-1:0]   exp_desc;
    logic [SL*ROWW-1:0] exp_row;
    logic [SL-1:0]      exp_valid;
    logic               exp_ovf, exp_late;
    int                 exp_busy_len;
    logic [RW-1:0]      exp_rgb;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_hit(input int k, input int line);
        int y;
        y = int'(oam[k][9:0]);
        return oam[k][31] && (line >= y) && (line - y < H);
    endfunction

    // Sprites are taken in index order; only entries checked before the next line_start count.
    task automatic model_scan(input int line, input int t);
        int hits, o, lim, dy;
        hits = 0;
        o    = -1;
        for (int k = 0; k < NUM; k++) begin
            if (is_hit(k, line)) begin
                if (hits == SL && o < 0) o = k;
                hits++;
            end
        end
        exp_busy_len = (o >= 0) ? o + 2 : NUM + 1;
        exp_late     = (t <= exp_busy_len);
        exp_desc  = '0;
        exp_row   = '0;
        exp_valid = '0;
        exp_ovf   = 1'b0;
        hits      = 0;
        lim       = (t - 2 < NUM - 1) ? t - 2 : NUM - 1;
        for (int k = 0; k <= lim; k++) begin
            if (!exp_ovf && is_hit(k, line)) begin
                if (hits < SL) begin
                    dy = line - int'(oam[k][9:0]);
                    exp_desc[hits*32 +: 32]     = oam[k];
                    exp_row[hits*ROWW +: ROWW]  = ROWW'(oam[k][30] ? H - 1 - dy : dy);
                    exp_valid[hits]             = 1'b1;
                    hits++;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [RW-1:0] model_comp(input logic [SL-1:0] opq, input logic [SL*RW-1:0] pix,
                                                 input logic [RW-1:0] bg, input logic bgo);
        for (int i = 0; i < SL; i++)
            if (exp_valid[i] && opq[i])
                return (exp_desc[i*32+28] && bgo) ? bg : pix[i*RW +: RW];
        return bg;
    endfunction

    task automatic clear_oam();
        for (int k = 0; k < NUM; k++) oam[k] = 32'h0;
    endtask

    task automatic pulse(input logic [9:0] l);
        bus.line_start = 1'b1;
        bus.next_line  = l;
        @(posedge clk); #1;
        bus.line_start = 1'b0;
    endtask

    // Evaluate the given line, issue the next line_start t cycles later, then check the committed bank.
    task automatic run_scan(input int line, input int t, input string tag);
        model_scan(line, t);
        pulse(10'(line));
        check({tag, ":busy_start"}, 256'(bus.scan_busy), 256'(1'b1));
        for (int c = 1; c < t; c++) begin
            @(posedge clk); #1;
            if (c == exp_busy_len - 1 || c == exp_busy_len)
                check({tag, ":busy"}, 256'(bus.scan_busy), 256'(c < exp_busy_len));
        end
        pulse(10'($urandom_range(0, 1023)));
        check({tag, ":desc"},  256'(bus.slot_desc),  256'(exp_desc));
        check({tag, ":row"},   256'(bus.slot_row),   256'(exp_row));
        check({tag, ":valid"}, 256'(bus.slot_valid), 256'(exp_valid));
        check({tag, ":ovf"},   256'(bus.overflow),   256'(exp_ovf));
        check({tag, ":late"},  256'(bus.scan_late),  256'(exp_late));
    endtask

    task automatic pix_step(input logic [SL-1:0] opq, input logic [SL*RW-1:0] pix,
                            input logic [RW-1:0] bg, input logic bgo, input logic pv, input string tag);
        bus.slot_opaque = opq;
        bus.slot_pix    = pix;
        bus.bg_rgb      = bg;
        bus.bg_opaque   = bgo;
        bus.pix_valid   = pv;
        if (pv) exp_rgb = model_comp(opq, pix, bg, bgo);
        @(posedge clk); #1;
        bus.pix_valid = 1'b0;
        check({tag, ":rgb"},  256'(bus.rgb_out),   256'(exp_rgb));
        check({tag, ":rvld"}, 256'(bus.rgb_valid), 256'(pv));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":desc"},  256'(bus.slot_desc),  256'(0));
        check({tag, ":row"},   256'(bus.slot_row),   256'(0));
        check({tag, ":valid"}, 256'(bus.slot_valid), 256'(0));
        check({tag, ":busy"},  256'(bus.scan_busy),  256'(0));
        check({tag, ":ovf"},   256'(bus.overflow),   256'(0));
        check({tag, ":late"},  256'(bus.scan_late),  256'(0));
        check({tag, ":addr"},  256'(bus.oam_addr),   256'(0));
        check({tag, ":rgb"},   256'(bus.rgb_out),    256'(0));
        check({tag, ":rvld"},  256'(bus.rgb_valid),  256'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SL*RW-1:0] pix;
        int line, t, span, dy, y;
        logic [31:0] r;

        rstn            = 1'b0;
        bus.line_start  = 1'b0;
        bus.next_line   = '0;
        bus.slot_pix    = '0;
        bus.slot_opaque = '0;
        bus.pix_valid   = 1'b0;
        bus.bg_rgb      = '0;
        bus.bg_opaque   = 1'b0;
        exp_rgb         = '0;
        clear_oam();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rstn = 1'b1;
        @(posedge clk); #1;

        // Two sprites on the evaluated line, rows 5.
        clear_oam();
        oam[3] = {1'b1, 3'b000, 8'h33, 10'd40, 10'd100};
        oam[7] = {1'b1, 3'b001, 8'h77, 10'd90, 10'd100};
        run_scan(105, 70, "two_sprites");
        check("two_sprites:valid_lit", 256'(bus.slot_valid), 256'(8'h03));
        check("two_sprites:rows_lit",  256'(bus.slot_row[7:0]), 256'(8'h55));

        // Ten sprites on one line: eight slots, overflow, early stop.
        clear_oam();
        for (int k = 0; k < 10; k++) oam[k] = {1'b1, 3'b000, 8'(k), 10'(k * 8), 10'd20};
        run_scan(20, 70, "overflow");
        check("overflow:valid_lit", 256'(bus.slot_valid), 256'(8'hFF));
        check("overflow:ovf_lit",   256'(bus.overflow),   256'(1'b1));

        // Sprite near the bottom of the line range must not wrap to the top.
        clear_oam();
        oam[0] = {1'b1, 3'b000, 8'h01, 10'd0, 10'd1020};
        run_scan(5, 70, "nowrap");

        clear_oam();
        oam[0] = {1'b1, 3'b100, 8'h02, 10'd0, 10'd50};
        run_scan(50, 70, "vflip");
        check("vflip:row_lit", 256'(bus.slot_row[3:0]), 256'(4'd15));

        // Slot 0 behind background, slot 1 in front.
        clear_oam();
        oam[0] = {1'b1, 3'b001, 8'h10, 10'd0, 10'd0};
        oam[1] = {1'b1, 3'b000, 8'h11, 10'd0, 10'd0};
        run_scan(0, 70, "comp_setup");
        pix = '0;
        pix[0 +: RW]  = 12'h0AB;
        pix[RW +: RW] = 12'hF00;
        pix_step(8'h03, pix, 12'h123, 1'b1, 1'b1, "comp_behind");
        check("comp_behind:lit", 256'(bus.rgb_out), 256'(12'h123));
        pix_step(8'h03, pix, 12'h123, 1'b0, 1'b1, "comp_bg_clear");
        check("comp_bg_clear:lit", 256'(bus.rgb_out), 256'(12'h0AB));
        pix_step(8'h02, pix, 12'h123, 1'b1, 1'b1, "comp_transp");
        check("comp_transp:lit", 256'(bus.rgb_out), 256'(12'hF00));
        pix_step(8'h01, pix, 12'h456, 1'b0, 1'b0, "comp_hold");

        // Next line_start arrives while the scan is still running.
        clear_oam();
        oam[5]  = {1'b1, 3'b000, 8'h05, 10'd0, 10'd295};
        oam[12] = {1'b1, 3'b000, 8'h0C, 10'd0, 10'd295};
        oam[18] = {1'b1, 3'b000, 8'h12, 10'd0, 10'd295};
        oam[19] = {1'b1, 3'b000, 8'h13, 10'd0, 10'd295};
        oam[25] = {1'b1, 3'b000, 8'h19, 10'd0, 10'd295};
        run_scan(300, 20, "late");
        check("late:valid_lit", 256'(bus.slot_valid), 256'(8'h07));
        check("late:flag_lit",  256'(bus.scan_late),  256'(1'b1));

        // Asynchronous reset in the middle of a scan.
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        check_all_zero("mid_reset");
        rstn    = 1'b1;
        exp_rgb = '0;
        @(posedge clk); #1;

        for (int trial = 0; trial < 24; trial++) begin
            line = int'($urandom_range(0, 1023));
            span = int'($urandom_range(16, 300));
            for (int k = 0; k < NUM; k++) begin
                r  = $urandom;
                dy = int'($urandom_range(0, span)) - 4;
                y  = (line - dy) & 1023;
                oam[k] = {($urandom_range(0, 2) != 0), r[30:10], 10'(y)};
            end
            t = ($urandom_range(0, 1) == 1) ? 70 : int'($urandom_range(1, 66));
            run_scan(line, t, $sformatf("rnd%0d", trial));
            for (int p = 0; p < 4; p++) begin
                for (int i = 0; i < SL; i++) pix[i*RW +: RW] = RW'($urandom);
                pix_step(SL'($urandom), pix, RW'($urandom), 1'($urandom),
                         ($urandom_range(0, 3) != 0), $sformatf("rnd%0d_px%0d", trial, p));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
